// File: rtl/clock_divide_pkg.sv
// Shared types and helpers for the runtime-programmable clock-divide controller.
// The high phase of a period is rounded up, so odd divisors are high one cycle longer than low.
package clock_divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int DIV_MIN = 2;

    function automatic int unsigned half_period(input int unsigned div);
        return (div + 1) >> 1;
    endfunction

endpackage

// File: rtl/clock_divide_core.sv
// Period counter with registered duty compare and last-cycle tick.
// run and div are the values for the coming cycle; load restarts the period at 0.
module clock_divide_core
    import clock_divide_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d = '0;
        if (run && !load) begin
            cnt_d = cnt_q + 1'b1;
        end
        half      = CNT_W'(half_period(32'(div)));
        clk_out_d = run && (cnt_d < half);
        tick_d    = run && (cnt_d == div - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clock_divide_ctrl.sv
// Divisor handshake, run/stop sequencing and period-boundary divisor switching
// around a single counter-based divider.
module clock_divide_ctrl
    import clock_divide_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             xfer, legal, run, load;

    // A transfer happens on any cycle with cfg_valid && cfg_ready; cfg_ready only
    // depends on rst and the current state, and cfg_div must hold while stalled.
    assign cfg_ready = !rst && (state_q == IDLE || state_q == RUN);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = cfg_div >= CNT_W'(DIV_MIN);

    // tick is registered, so it is high exactly on the last cycle of the period.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        err_d   = xfer && !legal;
        unique case (state_q)
            IDLE: begin
                if (xfer && legal) div_d = cfg_div;
                if (enable)        state_d = RUN;
            end
            RUN: begin
                if (xfer && legal) begin
                    if (tick) begin
                        div_d   = cfg_div;
                        state_d = enable ? RUN : IDLE;
                    end else begin
                        pend_d  = cfg_div;
                        state_d = PEND;
                    end
                end else if (!enable) begin
                    state_d = tick ? IDLE : STOP;
                end
            end
            PEND: begin
                if (tick) begin
                    div_d   = pend_q;
                    state_d = enable ? RUN : IDLE;
                end
            end
            STOP: begin
                if (enable)    state_d = RUN;
                else if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run  = (state_d != IDLE);
    assign load = (state_q == IDLE) || tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= CNT_W'(DEFAULT_DIV);
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    clock_divide_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .load    (load),
        .div     (div_d),
        .clk_out (clk_out),
        .tick    (tick)
    );

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule
